uart_frame_tx: RTL
==================

// Module: uart_frame_tx
// PURPOSE
// - Return-path counterpart of the UART command-frame receiver: serialises one 4-byte frame
//   (cmd, address, data LSB, data MSB) onto a UART line, 8N1, LSB-first.
// - Sits between on-chip response logic (e.g. SPI read-back) and the FPGA serial output pin.
// - Byte timing must match the receive side's bit period so host tools use one baud setting.
// PARAMETERS
// - CLKS_PER_BIT  52  clk cycles per UART bit (min 2; smaller values are an elaboration error)
// - GAP_BITS      0   extra idle (mark) bit periods inserted between bytes of one frame
// PORTS
// - clk          in   1   system clock, all logic on posedge
// - reset        in   1   synchronous, active-high reset
// - frame_valid  in   1   frame fields valid; held until accepted
// - frame_ready  out  1   block can accept a frame this cycle
// - cmd          in   8   command byte (sent 1st)
// - address      in   8   address byte (sent 2nd)
// - data         in   16  data word; [7:0] sent 3rd, [15:8] sent 4th
// - tx           out  1   UART serial output, idles high
// - busy         out  1   high from acceptance until frame_done inclusive
// - frame_done   out  1   one-cycle pulse after the final stop bit of a frame
// BEHAVIOUR
// - Reset values: tx=1, frame_ready=1, busy=0, frame_done=0; FSM=F_IDLE, counters=0.
// - Accept = frame_valid && frame_ready at a posedge (cycle N); fields registered; later input
//   changes ignored. frame_ready=1 only in F_IDLE.
// - Frame FSM: F_IDLE -accept-> F_SEND (byte_idx 0..3) -last byte done-> F_DONE -1 cycle-> F_IDLE.
// - Byte FSM: B_IDLE -> B_START (tx=0) -> B_DATA (bits 0..7, tx=bit) -> B_STOP (tx=1)
//   -> B_GAP (tx=1, GAP_BITS periods, skipped when 0 or after last byte) -> next byte / done.
// - Each bit lasts exactly CLKS_PER_BIT cycles; bit counter 0..CLKS_PER_BIT-1, wraps per bit.
// - Latency: tx falls in cycle N+1. Byte k start bit begins at N+1+k*(10+GAP_BITS)*CLKS_PER_BIT.
// - frame_done high in cycle N+1+(40+3*GAP_BITS)*CLKS_PER_BIT; frame_ready returns high in the
//   following cycle (F_IDLE), so back-to-back frames have exactly 1 idle clk between stop/start.
// - frame_valid asserted while busy: no effect, frame remains pending until frame_ready.
// - reset mid-frame: in-flight frame aborted, tx=1 the next cycle, no frame_done.
// - No byte is ever truncated; tx is glitch-free (registered output).
// CONFIGURATION
// - FRAME_CHECKSUM_EN defined: 5th byte appended = cmd ^ address ^ data[7:0] ^ data[15:8];
//   byte_idx 0..4; frame_done at N+1+(50+4*GAP_BITS)*CLKS_PER_BIT.
// - Not defined: 4-byte frames exactly as above; no checksum logic generated.
// STRUCTURE
// - Package uart_frame_pkg: frame_state_e {F_IDLE,F_SEND,F_DONE}, byte_state_e
//   {B_IDLE,B_START,B_DATA,B_STOP,B_GAP}, FRAME_BYTES const (4 or 5 per macro), byte_idx_t.
// - Sub-module uart_tx_byte: byte-level serialiser (start/data/stop/gap, bit timer), with
//   byte_valid/byte_ready/byte_done handshake; uart_frame_tx holds frame FSM + byte mux.
// TESTING (bench uses CLKS_PER_BIT=4, GAP_BITS=0 unless stated)
// - Reset then idle 100 cycles -> tx=1, frame_ready=1, busy=0, frame_done never high.
// - cmd=8'hA5,address=8'h3C,data=16'h1234 -> line decodes A5,3C,34,12; tx=0 at N+1;
//   frame_done only at N+161.
// - Two frames, frame_valid held high -> second start bit exactly 1 clk after frame_done cycle.
// - GAP_BITS=2, same frame -> 8 extra mark-cycles between bytes; frame_done at N+185.
// - reset asserted at cycle N+50 -> tx=1 next cycle, no frame_done, new frame sends cleanly.
// - FRAME_CHECKSUM_EN, cmd=01,address=02,data=0403 -> 5th byte 04; frame_done at N+201.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and frame constants for the UART frame transmitter (honours FRAME_CHECKSUM_EN)
package uart_frame_pkg;

    typedef logic [1:0] frame_state_e;
    localparam frame_state_e F_IDLE = 2'd0;
    localparam frame_state_e F_SEND = 2'd1;
    localparam frame_state_e F_DONE = 2'd2;

    typedef logic [2:0] byte_state_e;
    localparam byte_state_e B_IDLE  = 3'd0;
    localparam byte_state_e B_START = 3'd1;
    localparam byte_state_e B_DATA  = 3'd2;
    localparam byte_state_e B_STOP  = 3'd3;
    localparam byte_state_e B_GAP   = 3'd4;

`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_BYTES = 5;
`else
    localparam int FRAME_BYTES = 4;
`endif

    typedef logic [2:0] byte_idx_t;
    localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(FRAME_BYTES - 1);

    // XOR of all payload bytes, appended as the trailing byte when enabled
    function automatic logic [7:0] frame_checksum(input logic [7:0] c, input logic [7:0] a,
                                                  input logic [15:0] d);
        return c ^ a ^ d[7:0] ^ d[15:8];
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - frame request handshake between response logic and the UART transmitter
interface uart_frame_tx_if;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  cmd;
    logic [7:0]  address;
    logic [15:0] data;

    modport master (output frame_valid, output cmd, output address, output data, input frame_ready);
    modport slave  (input frame_valid, input cmd, input address, input data, output frame_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first byte serialiser with optional inter-byte idle gap
module uart_tx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 52,
    parameter int GAP_BITS     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       tx
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
    end

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    byte_state_e     state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      shreg;
    logic            last_r;
    logic            tick;

    assign tick = (bit_cnt == BIT_LAST);

    // Byte ends on the last cycle of the stop bit, or of the gap when one follows
    always_comb begin
        byte_done = 1'b0;
        if (tick) begin
            if (state == B_STOP && (GAP_BITS == 0 || last_r)) begin
                byte_done = 1'b1;
            end
            if (state == B_GAP && gap_cnt == GAP_LAST) begin
                byte_done = 1'b1;
            end
        end
    end

    // A new byte may be taken while idle or on the final cycle of the current one,
    // so consecutive bytes abut with no idle clock between stop and start
    assign byte_ready = (state == B_IDLE) || byte_done;

    // Bit timer, byte FSM and registered line output
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= B_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            last_r  <= 1'b0;
            tx      <= 1'b1;
        end else begin
            if (state == B_IDLE || tick) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (byte_ready) begin
                if (byte_valid) begin
                    state  <= B_START;
                    shreg  <= byte_data;
                    last_r <= byte_last;
                    tx     <= 1'b0;
                end else begin
                    state  <= B_IDLE;
                    tx     <= 1'b1;
                end
            end else if (tick) begin
                case (state)
                    B_START: begin
                        state   <= B_DATA;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                    end
                    B_DATA: begin
                        if (bit_idx == 3'd7) begin
                            state <= B_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end
                    B_STOP: begin
                        state   <= B_GAP;
                        gap_cnt <= '0;
                        tx      <= 1'b1;
                    end
                    B_GAP: begin
                        gap_cnt <= gap_cnt + 1'b1;
                        tx      <= 1'b1;
                    end
                    default: begin
                        state <= B_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - serialises a cmd/address/data frame onto a UART line (FRAME_CHECKSUM_EN appends XOR byte)
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 52,
    parameter int GAP_BITS     = 0
) (
    input  logic             clk,
    input  logic             reset,
    uart_frame_tx_if.slave   frame,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    frame_state_e f_state;
    byte_idx_t    byte_idx;
    byte_idx_t    next_idx;
    logic [7:0]   cmd_r;
    logic [7:0]   addr_r;
    logic [15:0]  data_r;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]   csum_r;
`endif

    logic         accept;
    logic         byte_valid;
    logic         byte_ready;
    logic         byte_done;
    logic         byte_last;
    logic [7:0]   byte_data;

    assign frame.frame_ready = (f_state == F_IDLE) && byte_ready;
    assign accept            = frame.frame_valid && frame.frame_ready;
    assign next_idx          = byte_idx + 3'd1;
    assign busy              = (f_state != F_IDLE);
    assign frame_done        = (f_state == F_DONE);

    // The first byte comes straight from the inputs so the start bit follows acceptance
    // by one clock; later bytes come from the registered fields
    always_comb begin
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = frame.cmd;
        if (f_state == F_IDLE) begin
            byte_valid = accept;
        end else if (f_state == F_SEND && byte_idx != LAST_BYTE_IDX) begin
            byte_valid = 1'b1;
            byte_last  = (next_idx == LAST_BYTE_IDX);
            case (next_idx)
                3'd1:    byte_data = addr_r;
                3'd2:    byte_data = data_r[7:0];
                3'd3:    byte_data = data_r[15:8];
`ifdef FRAME_CHECKSUM_EN
                3'd4:    byte_data = csum_r;
`endif
                default: byte_data = cmd_r;
            endcase
        end
    end

    // Frame FSM: capture fields on accept, step through bytes, pulse done for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            f_state  <= F_IDLE;
            byte_idx <= '0;
            cmd_r    <= '0;
            addr_r   <= '0;
            data_r   <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_r   <= '0;
`endif
        end else begin
            case (f_state)
                F_IDLE: begin
                    if (accept) begin
                        cmd_r    <= frame.cmd;
                        addr_r   <= frame.address;
                        data_r   <= frame.data;
`ifdef FRAME_CHECKSUM_EN
                        csum_r   <= frame_checksum(frame.cmd, frame.address, frame.data);
`endif
                        byte_idx <= '0;
                        f_state  <= F_SEND;
                    end
                end
                F_SEND: begin
                    if (byte_done) begin
                        if (byte_idx == LAST_BYTE_IDX) begin
                            f_state <= F_DONE;
                        end else begin
                            byte_idx <= next_idx;
                        end
                    end
                end
                F_DONE: begin
                    f_state <= F_IDLE;
                end
                default: begin
                    f_state <= F_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_BITS     (GAP_BITS)
    ) u_byte (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .tx         (tx)
    );

endmodule
